// File: rtl/dlfloat_operand_tx.sv
`timescale 1ns/1ps
// Two-beat DLFloat16 operand transmitter: buffers (A,B) pairs and drives them on the shared bus
// in lock-step with the receiver's A/B alternation, zero-bubbling empty slots and tagging results.
module dlfloat_operand_tx #(
  parameter int DEPTH      = 4,
  parameter int RESULT_LAT = 4,
  parameter int CNT_W      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [15:0]               in_a,
  input  logic [15:0]               in_b,
  output logic [15:0]               tx_data,
  output logic                      tx_phase,
  output logic                      tx_real,
  input  logic [15:0]               res_in,
  output logic                      res_valid,
  output logic [15:0]               res_data,
  output logic [$clog2(DEPTH):0]    fifo_count,
  output logic [CNT_W-1:0]          pairs_sent
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
  } pair_t;

  typedef enum logic {A_SLOT = 1'b0, B_SLOT = 1'b1} state_e;

  state_e            state_q, state_d;
  pair_t             mem_q [DEPTH];
  logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic [15:0]       data_q, data_d;
  logic [15:0]       cur_b_q, cur_b_d;
  logic [15:0]       res_data_q, res_data_d;
  logic              real_q, real_d;
  logic              res_vld_q, res_vld_d;
  logic [CNT_W-1:0]  sent_q, sent_d;
  logic [RESULT_LAT-1:0] tag_q, tag_d;

  logic  push, empty, take, pop_mem, wr_en, tag_in;
  pair_t head;

  assign in_ready = (cnt_q != FULL);
  assign push     = in_valid && in_ready;
  assign empty    = (cnt_q == '0);
  assign take     = (state_q == B_SLOT) && (!empty || push);
  assign pop_mem  = (state_q == B_SLOT) && !empty;
  // An empty FIFO hands a pair offered in the B slot straight to the bus; it never gets stored.
  assign wr_en    = push && !(take && empty);
  assign head     = empty ? {in_a, in_b} : mem_q[rd_q];

  always_comb begin
    wr_d  = wr_en   ? wr_q + AW'(1) : wr_q;
    rd_d  = pop_mem ? rd_q + AW'(1) : rd_q;
    cnt_d = cnt_q + (AW+1)'(wr_en) - (AW+1)'(pop_mem);
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cur_b_d = cur_b_q;
    real_d  = real_q;
    sent_d  = sent_q;
    tag_in  = 1'b0;
    case (state_q)
      A_SLOT: begin
        state_d = B_SLOT;
        data_d  = cur_b_q;
        tag_in  = real_q;
        if (real_q) sent_d = sent_q + CNT_W'(1);
      end
      B_SLOT: begin
        state_d = A_SLOT;
        if (take) begin
          data_d  = head.a;
          cur_b_d = head.b;
          real_d  = 1'b1;
        end else begin
          data_d  = '0;
          cur_b_d = '0;
          real_d  = 1'b0;
        end
      end
    endcase
  end

  always_comb begin
    tag_d    = '0;
    tag_d[0] = tag_in;
    for (int i = 1; i < RESULT_LAT; i++) tag_d[i] = tag_q[i-1];
    res_vld_d  = tag_q[RESULT_LAT-1];
    res_data_d = tag_q[RESULT_LAT-1] ? res_in : res_data_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= A_SLOT;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
      cur_b_q    <= '0;
      real_q     <= 1'b0;
      sent_q     <= '0;
      tag_q      <= '0;
      res_vld_q  <= 1'b0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      cur_b_q    <= cur_b_d;
      real_q     <= real_d;
      sent_q     <= sent_d;
      tag_q      <= tag_d;
      res_vld_q  <= res_vld_d;
      res_data_q <= res_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= {in_a, in_b};
  end

  assign tx_data    = data_q;
  assign tx_phase   = state_q;
  assign tx_real    = real_q;
  assign res_valid  = res_vld_q;
  assign res_data   = res_data_q;
  assign fifo_count = cnt_q;
  assign pairs_sent = sent_q;

endmodule

// File: tb/tb_dlfloat_operand_tx.sv
`timescale 1ns/1ps
// Scoreboard bench for dlfloat_operand_tx: stimulus queues expected pairs/results,
// a negedge monitor pops and compares whatever the DUT presents on the bus and result port.
module tb_dlfloat_operand_tx;
  localparam int DEPTH = 4;
  localparam int LAT   = 4;
  localparam int CW    = 8;
  localparam logic [2:0] FULLC = 3'd4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_a = '0, in_b = '0, res_in = '0;
  logic        in_ready, tx_phase, tx_real, res_valid;
  logic [15:0] tx_data, res_data;
  logic [2:0]  fifo_count;
  logic [CW-1:0] pairs_sent;

  dlfloat_operand_tx #(.DEPTH(DEPTH), .RESULT_LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .tx_data(tx_data), .tx_phase(tx_phase),
    .tx_real(tx_real), .res_in(res_in), .res_valid(res_valid), .res_data(res_data),
    .fifo_count(fifo_count), .pairs_sent(pairs_sent)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] a; logic [15:0] b; } pair_t;
  typedef struct { int cyc; logic [15:0] d; } res_t;

  pair_t exp_q[$];
  res_t  res_q[$];
  pair_t mon_p;
  res_t  mon_r, new_r;
  int tests = 0, fails = 0, cyc = 0;
  bit mon_en = 0, first = 1, pending = 0, full_seen = 0;
  logic last_phase = 1'b0;
  logic [15:0] exp_b = '0;
  logic [CW-1:0] sent_model = '0;
  logic [2:0] cnt_exp [4] = '{3'd1, 3'd1, 3'd2, 3'd2};

  function automatic logic [15:0] resfun(int c);
    return 16'(c * 37 + 32'h1234);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_phase(input logic p);
    for (int i = 0; i < 4 && tx_phase != p; i++) tick();
  endtask

  task automatic offer(input logic [15:0] a, input logic [15:0] b);
    bit ok;
    pair_t p;
    ok = 0;
    p.a = a;
    p.b = b;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(p);
        ok = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL push timeout: in_ready stayed 0, expected 1 within 64 cycles");
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (exp_q.size() != 0 || pending); i++) tick();
    chk("drain complete", 32'(exp_q.size()), 32'(0));
    repeat (2) tick();
  endtask

  // result input changes every cycle so a capture at the wrong edge shows up
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      res_in = resfun(cyc);
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (first) chk("first slot is A", 32'(tx_phase), 32'(0));
      else       chk("phase toggle", 32'(tx_phase), 32'(!last_phase));
      first = 0;
      last_phase = tx_phase;
      chk("in_ready", 32'(in_ready), 32'(fifo_count != FULLC));
      if (fifo_count == FULLC) full_seen = 1;
      if (!tx_real) chk("bubble data", 32'(tx_data), 32'(0));
      if (!tx_phase) begin
        if (tx_real) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected pair: got A 0x%h, expected bubble", tx_data);
          end else begin
            mon_p = exp_q.pop_front();
            chk("A word", 32'(tx_data), 32'(mon_p.a));
            exp_b = mon_p.b;
            pending = 1;
          end
        end
      end else begin
        if (pending) begin
          chk("B real", 32'(tx_real), 32'(1));
          chk("B word", 32'(tx_data), 32'(exp_b));
          sent_model++;
          chk("pairs_sent", 32'(pairs_sent), 32'(sent_model));
          new_r.cyc = cyc + LAT;
          new_r.d   = resfun(cyc + LAT - 1);
          res_q.push_back(new_r);
          pending = 0;
        end else begin
          chk("B slot bubble", 32'(tx_real), 32'(0));
        end
      end
      if (res_valid) begin
        if (res_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected res_valid: got res_data 0x%h, expected no pulse", res_data);
        end else begin
          mon_r = res_q.pop_front();
          chk("res cycle", 32'(cyc), 32'(mon_r.cyc));
          chk("res_data", 32'(res_data), 32'(mon_r.d));
        end
      end else if (res_q.size() != 0 && res_q[0].cyc <= cyc) begin
        tests++;
        fails++;
        $display("FAIL missing res_valid: got 0, expected pulse at cycle %0d", res_q[0].cyc);
        void'(res_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: still running at %0t, expected completion", $time);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

  initial begin
    #2 rst = 1'b0;
    #1;
    chk("reset tx_data", 32'(tx_data), 32'(0));
    chk("reset tx_phase", 32'(tx_phase), 32'(0));
    chk("reset tx_real", 32'(tx_real), 32'(0));
    chk("reset res_valid", 32'(res_valid), 32'(0));
    chk("reset res_data", 32'(res_data), 32'(0));
    chk("reset fifo_count", 32'(fifo_count), 32'(0));
    chk("reset pairs_sent", 32'(pairs_sent), 32'(0));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    first = 1;
    mon_en = 1;
    chk("in_ready after release", 32'(in_ready), 32'(1));

    // idle: bubbles only
    repeat (10) tick();
    chk("idle pairs_sent", 32'(pairs_sent), 32'(0));

    // single pair pushed in a B slot goes straight to the next A slot
    wait_phase(1'b1);
    in_valid = 1'b1;
    in_a = 16'h3E00;
    in_b = 16'h4000;
    @(negedge clk);
    chk("single in_ready", 32'(in_ready), 32'(1));
    mon_p.a = 16'h3E00;
    mon_p.b = 16'h4000;
    exp_q.push_back(mon_p);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("single A data", 32'(tx_data), 32'(16'h3E00));
    chk("single A phase", 32'(tx_phase), 32'(0));
    chk("single A real", 32'(tx_real), 32'(1));
    chk("single bypass count", 32'(fifo_count), 32'(0));
    tick();
    chk("single B data", 32'(tx_data), 32'(16'h4000));
    chk("single B phase", 32'(tx_phase), 32'(1));
    chk("single pairs_sent", 32'(pairs_sent), 32'(1));
    repeat (LAT + 2) tick();
    chk("single result seen", 32'(res_q.size()), 32'(0));

    // back-to-back burst until the FIFO fills
    wait_phase(1'b1);
    for (int i = 0; i < 2 * DEPTH + 2; i++) offer(16'h1100 + 16'(i), 16'h2200 + 16'(i));
    in_valid = 1'b0;
    chk("burst reached full", 32'(full_seen), 32'(1));
    drain();

    // push coinciding with pop keeps the count
    wait_phase(1'b0);
    for (int i = 0; i < 4; i++) begin
      offer(16'h3300 + 16'(i), 16'h4400 + 16'(i));
      chk("count push/pop", 32'(fifo_count), 32'(cnt_exp[i]));
    end
    in_valid = 1'b0;
    drain();

    // asynchronous reset mid B slot with three pairs buffered
    wait_phase(1'b0);
    for (int i = 0; i < 10 && !(fifo_count == 3'd3 && tx_phase); i++)
      offer(16'h5500 + 16'(i), 16'h6600 + 16'(i));
    in_valid = 1'b0;
    chk("three buffered", 32'(fifo_count), 32'(3));
    chk("reset in B slot", 32'(tx_phase), 32'(1));
    #2;
    mon_en = 0;
    rst = 1'b0;
    #1;
    chk("mid reset tx_data", 32'(tx_data), 32'(0));
    chk("mid reset tx_phase", 32'(tx_phase), 32'(0));
    chk("mid reset tx_real", 32'(tx_real), 32'(0));
    chk("mid reset res_valid", 32'(res_valid), 32'(0));
    chk("mid reset res_data", 32'(res_data), 32'(0));
    chk("mid reset fifo_count", 32'(fifo_count), 32'(0));
    chk("mid reset pairs_sent", 32'(pairs_sent), 32'(0));
    exp_q.delete();
    res_q.delete();
    pending = 0;
    sent_model = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    first = 1;
    mon_en = 1;
    chk("post reset in_ready", 32'(in_ready), 32'(1));
    chk("post reset fifo_count", 32'(fifo_count), 32'(0));
    repeat (LAT + 4) tick();
    offer(16'h7701, 16'h7802);
    offer(16'h7903, 16'h7A04);
    in_valid = 1'b0;
    drain();

    // long stream to wrap the pair counter (2 + 260 pairs = 262 mod 256)
    for (int i = 0; i < 260; i++) offer(16'h8000 + 16'(i), 16'hC000 + 16'(i));
    in_valid = 1'b0;
    drain();
    chk("pairs_sent wrapped", 32'(pairs_sent), 32'(8'd6));

    repeat (LAT + 4) tick();
    chk("results outstanding", 32'(res_q.size()), 32'(0));
    chk("pairs outstanding", 32'(exp_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
